game_flow_controller: RTL and testbench

//  Top-level sequencer for the Pac-Man game-logic datapath. It owns the round flow
//  (idle, ready countdown, play, death, respawn, level-up, game over) and the lives and

---
 rtl/game_pkg.sv | 32 +++
 rtl/move_tick_gen.sv | 44 ++++
 rtl/game_flow_controller.sv | 139 +++++++++++++
 tb/tb_game_flow_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the Pac-Man game-logic datapath: round states, move
// directions, sprite identifiers and the common timer width.
package game_pkg;

    localparam int TMR_W = 26;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READY     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_DYING     = 3'd3,
        ST_RESPAWN   = 3'd4,
        ST_LEVEL_UP  = 3'd5,
        ST_GAME_OVER = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        LEFT  = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        PACMAN = 3'd0,
        BLINKY = 3'd1,
        PINKY  = 3'd2,
        INKY   = 3'd3,
        CLYDE  = 3'd4
    } sprite_id_e;

endpackage

// File: rtl/move_tick_gen.sv
// Move-step pacing divider: counts 0..TICK_DIV-1 while enabled and emits a
// registered one-cycle pulse in the cycle after the count reaches TICK_DIV-1.
module move_tick_gen
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [TMR_W-1:0] DIV_LAST = TMR_W'(TICK_DIV - 1);

    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        // Clear wins so a partial count never survives a state change.
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            tick_d = (cnt_q == DIV_LAST);
            cnt_d  = tick_d ? '0 : cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/game_flow_controller.sv
// Round sequencer for the Pac-Man datapath: owns the game flow FSM, the state
// timer, the lives/level counters and the sprite reset / move strobes.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned TICK_DIV     = 2,
    parameter int unsigned READY_CYCLES = 50000000,
    parameter int unsigned DEATH_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pacman_is_dead,
    input  logic       dots_cleared,
    output logic       move_tick,
    output logic       sprite_rst,
    output logic       freeze,
    output logic [1:0] lives,
    output logic [3:0] level,
    output logic [2:0] game_state,
    output logic       game_over
);

    localparam logic [TMR_W-1:0] READY_LAST = TMR_W'(READY_CYCLES - 1);
    localparam logic [TMR_W-1:0] DEATH_LAST = TMR_W'(DEATH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       lives_q, lives_d;
    logic [3:0]       level_q, level_d;
    logic             start_q;
    logic             sprite_rst_q, sprite_rst_d;
    logic             freeze_q, freeze_d;
    logic             game_over_q, game_over_d;
    logic             start_edge;
    logic             div_clr;
    logic             div_en;

    assign start_edge = start & ~start_q;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_READY;
                    lives_d = 2'(LIVES);
                    level_d = 4'd1;
                end
            end
            ST_READY: begin
                if (timer_q == READY_LAST) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Death takes priority over clearing the maze in the same cycle.
                if (pacman_is_dead) begin
                    state_d = ST_DYING;
                end else if (dots_cleared) begin
                    state_d = ST_LEVEL_UP;
                    level_d = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
                end
            end
            ST_DYING: begin
                if (timer_q == DEATH_LAST) begin
                    if (lives_q <= 2'd1) begin
                        state_d = ST_GAME_OVER;
                        lives_d = 2'd0;
                    end else begin
                        state_d = ST_RESPAWN;
                        lives_d = lives_q - 2'd1;
                    end
                end
            end
            ST_RESPAWN:  state_d = ST_READY;
            ST_LEVEL_UP: state_d = ST_READY;
            ST_GAME_OVER: begin
                lives_d = 2'd0;
                if (start_edge) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        timer_d = '0;
        if ((state_d == state_q) && ((state_q == ST_READY) || (state_q == ST_DYING)))
            timer_d = timer_q + TMR_W'(1);

        sprite_rst_d = ((state_q == ST_IDLE) && (state_d == ST_READY)) ||
                       (state_d == ST_RESPAWN) || (state_d == ST_LEVEL_UP);
        freeze_d     = (state_d != ST_PLAY);
        game_over_d  = (state_d == ST_GAME_OVER);
    end

    // The divider only runs while PLAY persists; entry and exit both clear it.
    assign div_clr = (state_q != ST_PLAY) || (state_d != ST_PLAY);
    assign div_en  = (state_q == ST_PLAY);

    move_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_move_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr),
        .en   (div_en),
        .tick (move_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            lives_q      <= 2'd0;
            level_q      <= 4'd0;
            start_q      <= 1'b0;
            sprite_rst_q <= 1'b0;
            freeze_q     <= 1'b1;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            start_q      <= start;
            sprite_rst_q <= sprite_rst_d;
            freeze_q     <= freeze_d;
            game_over_q  <= game_over_d;
        end
    end

    assign sprite_rst = sprite_rst_q;
    assign freeze     = freeze_q;
    assign lives      = lives_q;
    assign level      = level_q;
    assign game_state = state_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed round scenarios plus random play,
// compared every cycle against a cycle-count based model of the game rules.
module tb_game_flow_controller;
    import game_pkg::*;

    localparam int LIVES_P  = 3;
    localparam int TDIV     = 4;
    localparam int READY_N  = 8;
    localparam int DEATH_N  = 6;

    localparam int P_IDLE = 0, P_READY = 1, P_PLAY = 2, P_DYING = 3;
    localparam int P_RESPAWN = 4, P_LEVEL_UP = 5, P_GO = 6;

    logic       clk;
    logic       rst;
    logic       start;
    logic       pacman_is_dead;
    logic       dots_cleared;
    logic       move_tick;
    logic       sprite_rst;
    logic       freeze;
    logic [1:0] lives;
    logic [3:0] level;
    logic [2:0] game_state;
    logic       game_over;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: state number, cycles spent in it, counters.
    int m_state, m_cnt, m_lives, m_level;
    bit m_srst, m_start_prev;

    game_flow_controller #(
        .LIVES        (LIVES_P),
        .TICK_DIV     (TDIV),
        .READY_CYCLES (READY_N),
        .DEATH_CYCLES (DEATH_N)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .pacman_is_dead (pacman_is_dead),
        .dots_cleared   (dots_cleared),
        .move_tick      (move_tick),
        .sprite_rst     (sprite_rst),
        .freeze         (freeze),
        .lives          (lives),
        .level          (level),
        .game_state     (game_state),
        .game_over      (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = P_IDLE; m_cnt = 0; m_lives = 0; m_level = 0;
        m_srst = 1'b0; m_start_prev = 1'b0;
    endfunction

    function automatic void model_update(input bit s, input bit d, input bit c);
        bit edge_s;
        int nxt;
        edge_s = s && !m_start_prev;
        m_start_prev = s;
        m_srst = 1'b0;
        nxt = m_state;
        case (m_state)
            P_IDLE: if (edge_s) begin
                nxt = P_READY; m_lives = LIVES_P; m_level = 1; m_srst = 1'b1;
            end
            P_READY: if (m_cnt == READY_N - 1) nxt = P_PLAY;
            P_PLAY: begin
                if (d) nxt = P_DYING;
                else if (c) begin
                    nxt = P_LEVEL_UP; m_srst = 1'b1;
                    m_level = (m_level + 1 > 15) ? 15 : m_level + 1;
                end
            end
            P_DYING: if (m_cnt == DEATH_N - 1) begin
                if (m_lives == 1) begin nxt = P_GO; m_lives = 0; end
                else begin nxt = P_RESPAWN; m_lives = m_lives - 1; m_srst = 1'b1; end
            end
            P_RESPAWN, P_LEVEL_UP: nxt = P_READY;
            P_GO: if (edge_s) nxt = P_IDLE;
            default: nxt = P_IDLE;
        endcase
        m_cnt = (nxt == m_state) ? m_cnt + 1 : 0;
        m_state = nxt;
    endfunction

    task automatic check_all(input string tag);
        bit e_tick;
        e_tick = (m_state == P_PLAY) && (m_cnt > 0) && (m_cnt % TDIV == 0);
        chk({tag, ".state"},  8'(game_state), 8'(m_state));
        chk({tag, ".tick"},   8'(move_tick),  8'(e_tick));
        chk({tag, ".srst"},   8'(sprite_rst), 8'(m_srst));
        chk({tag, ".freeze"}, 8'(freeze),     8'(m_state != P_PLAY));
        chk({tag, ".over"},   8'(game_over),  8'(m_state == P_GO));
        chk({tag, ".lives"},  8'(lives),      8'(m_lives));
        chk({tag, ".level"},  8'(level),      8'(m_level));
    endtask

    // Drive at the falling edge, let one rising edge pass, check at the next falling edge.
    task automatic step(input bit s, input bit d, input bit c);
        start = s; pacman_is_dead = d; dots_cleared = c;
        @(posedge clk);
        if (rst) model_reset();
        else model_update(s, d, c);
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int i;
        i = 0;
        while (m_state != target && i < budget) begin
            step(1'b0, 1'b0, 1'b0);
            i++;
        end
        chk({tag, ".reach"}, 8'(game_state), 8'(target));
    endtask

    initial begin
        bit rs;
        rst = 1'b1; start = 1'b0; pacman_is_dead = 1'b0; dots_cleared = 1'b0;
        model_reset();
        #1 check_all("reset");
        repeat (3) step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // Start a game and play until ticks are established.
        step(1'b1, 1'b0, 1'b0);
        chk("start.srst", 8'(sprite_rst), 8'd1);
        step(1'b0, 1'b0, 1'b0);
        run_until(P_PLAY, 20, "ready1");
        repeat (13) step(1'b0, 1'b0, 1'b0);

        // First death -> respawn with one life less.
        step(1'b0, 1'b1, 1'b0);
        chk("die1.freeze", 8'(freeze), 8'd1);
        run_until(P_RESPAWN, 20, "respawn1");
        chk("respawn1.lives", 8'(lives), 8'd2);
        chk("respawn1.srst", 8'(sprite_rst), 8'd1);
        run_until(P_PLAY, 20, "ready2");
        step(1'b0, 1'b1, 1'b0);
        run_until(P_PLAY, 30, "ready3");

        // Last life lost with start held across the transition into game over.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (14) step(1'b1, 1'b0, 1'b0);
        chk("go.over", 8'(game_over), 8'd1);
        chk("go.lives", 8'(lives), 8'd0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("go.exit", 8'(game_state), 8'(P_IDLE));
        step(1'b0, 1'b0, 1'b0);

        // Simultaneous death and clear, then repeated level-ups to saturation.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        run_until(P_PLAY, 20, "ready4");
        step(1'b0, 1'b1, 1'b1);
        chk("both.level", 8'(level), 8'd1);
        run_until(P_PLAY, 30, "ready5");
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 1'b1);
            if (k == 0) chk("lvlup.level", 8'(level), 8'd2);
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            run_until(P_PLAY, 20, "lvl");
        end
        chk("lvl.sat", 8'(level), 8'd15);

        // Asynchronous reset mid-DYING, then mid-PLAY on a tick cycle.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("arst_dying");
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        run_until(P_PLAY, 20, "ready6");
        repeat (4) step(1'b0, 1'b0, 1'b0);
        chk("pre_arst.tick", 8'(move_tick), 8'd1);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("arst_play");
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // Illegal state code recovers to IDLE on the next edge.
        force dut.state_q = state_e'(3'd7);
        #1 chk("illegal.forced", 8'(game_state), 8'd7);
        release dut.state_q;
        m_state = 7; m_cnt = 0;
        step(1'b0, 1'b0, 1'b0);
        chk("illegal.recover", 8'(game_state), 8'(P_IDLE));

        // Start presses during READY and PLAY are ignored.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("ready.ignore", 8'(game_state), 8'(P_READY));
        step(1'b0, 1'b0, 1'b0);
        run_until(P_PLAY, 20, "ready7");
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("play.ignore", 8'(game_state), 8'(P_PLAY));

        // Random play across all states.
        rs = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) rs = ~rs;
            step(rs, $urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
